// File: rtl/johnson_phase_decoder_if.sv
// Johnson decoder bus: sampled ring code and clear in, decoded phase/status out.
interface johnson_phase_decoder_if #(
    parameter int N         = 4,
    parameter int PW        = 3,
    parameter int REV_WIDTH = 8
);
    logic [N-1:0]         J;
    logic                 CLR;
    logic [PW-1:0]        PHASE;
    logic [2*N-1:0]       ONEHOT;
    logic                 VALID;
    logic                 STEP;
    logic [REV_WIDTH-1:0] REVS;
    logic                 ERR;

    modport master (
        output J, CLR,
        input  PHASE, ONEHOT, VALID, STEP, REVS, ERR
    );

    modport slave (
        input  J, CLR,
        output PHASE, ONEHOT, VALID, STEP, REVS, ERR
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Checks and decodes a Johnson ring code into phase, one-hot, revolution count and sticky error.
// Latency: one cycle, all outputs registered.
// Backpressure: none; J is sampled every cycle.
module johnson_phase_decoder #(
    parameter int N         = 4,
    parameter int PW        = 3,
    parameter int REV_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    johnson_phase_decoder_if.slave   bus
);

    logic [N-1:0]         prev_q;
    logic [PW-1:0]        phase_q, phase_n;
    logic [2*N-1:0]       onehot_q, onehot_n;
    logic                 valid_q, valid_n;
    logic                 step_q, step_n;
    logic [REV_WIDTH-1:0] revs_q, revs_n;
    logic                 err_q, err_n;

    // Legal codes are a run of ones anchored at bit 0, or its complement.
    function automatic logic is_legal(input logic [N-1:0] c);
        logic [N-1:0] low;
        logic         ok;
        ok = 1'b0;
        for (int k = 0; k <= N; k++) begin
            low = {N{1'b1}} >> (N - k);
            if (c == low || c == ~low) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [PW-1:0] decode(input logic [N-1:0] c);
        int ones;
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(c[i]);
        if (c[N-1]) ones = 2 * N - ones;
        return PW'(ones);
    endfunction

    function automatic logic [N-1:0] succ(input logic [N-1:0] c);
        return {c[N-2:0], ~c[N-1]};
    endfunction

    always_comb begin
        logic          legal_j;
        logic          legal_p;
        logic          err_set;
        logic          rev_inc;
        logic [PW-1:0] dec_j;

        legal_j = is_legal(bus.J);
        legal_p = is_legal(prev_q);
        dec_j   = decode(bus.J);
        err_set = 1'b0;
        rev_inc = 1'b0;
        phase_n = phase_q;
        valid_n = legal_j;
        step_n  = 1'b0;

        if (bus.J == prev_q) begin
            if (legal_j) phase_n = dec_j;
        end else if (!legal_j) begin
            err_set = 1'b1;
        end else if (legal_p && bus.J == succ(prev_q)) begin
            step_n  = 1'b1;
            phase_n = dec_j;
            rev_inc = (dec_j == '0);
        end else begin
            // Skip/backward step resyncs; leaving an illegal code is a recovery, not a new error.
            phase_n = dec_j;
            err_set = legal_p;
        end

        onehot_n = '0;
        if (legal_j) onehot_n[phase_n] = 1'b1;

        err_n  = err_set | (err_q & ~bus.CLR);
        revs_n = (bus.CLR ? '0 : revs_q) + REV_WIDTH'(rev_inc);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_q   <= '0;
            phase_q  <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            revs_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= bus.J;
            phase_q  <= phase_n;
            onehot_q <= onehot_n;
            valid_q  <= valid_n;
            step_q   <= step_n;
            revs_q   <= revs_n;
            err_q    <= err_n;
        end
    end

    assign bus.PHASE  = phase_q;
    assign bus.ONEHOT = onehot_q;
    assign bus.VALID  = valid_q;
    assign bus.STEP   = step_q;
    assign bus.REVS   = revs_q;
    assign bus.ERR    = err_q;

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
Downstream consumer of the prescaled 4-bit Johnson ring in the icestick LED demo. It samples the Johnson code every CLK and checks that it is legal and advances by exactly one legal step. It decodes the code to a phase index and a one-hot LED vector, counts full revolutions, and keeps a sticky error flag. It sits between the Johnson counter output and the J3 LED pins / debug header.

Parameters:
N, 4, Johnson register width; 2N legal states.
PW, 3, PHASE width; must satisfy 2^PW >= 2N.
REV_WIDTH, 8, revolution counter width.

Ports:
CLK  input  1  system clock (CLKIN at top level); all state on rising edge.
RESET  input  1  asynchronous, active-high reset.
J  input  N  Johnson code from the upstream ring, synchronous to CLK.
CLR  input  1  synchronous clear of ERR and REVS.
PHASE  output  PW  decoded phase index 0..2N-1.
ONEHOT  output  2N  one-hot of PHASE; all zero when the code is illegal.
VALID  output  1  last sampled J was a legal Johnson code.
STEP  output  1  one-cycle pulse: legal single-step advance detected.
REVS  output  REV_WIDTH  completed revolutions, modulo 2^REV_WIDTH.
ERR  output  1  sticky: illegal code or bad transition seen.

Behaviour:
- Reset (async, RESET=1): prev-code register=0; PHASE=0, ONEHOT=0, VALID=0, STEP=0, REVS=0, ERR=0. Prev=0 matches the Johnson ring's power-up state.
- Legal codes: contiguous ones anchored at bit 0 (0000, 0001, 0011, 0111, 1111 for N=4), or contiguous ones anchored at bit N-1 (1110, 1100, 1000). All other codes are illegal.
- Decode: if J[N-1]=0 then phase=popcount(J); else phase=2N-popcount(J). For N=4: 0000→0, 0111→3, 1111→4, 1000→7.
- Successor of code c: {c[N-2:0], ~c[N-1]}. This is the shift-left-with-inverted-feedback of the ring.
- Each cycle, compare J with prev. Prev <= J every cycle, regardless of outcome.
  - J==prev: STEP=0; PHASE/VALID/ONEHOT refresh from J; REVS and ERR unchanged.
  - J legal, J==succ(prev), prev legal:
    - STEP=1.
    - PHASE=decode(J).
    - REVS+1 if the new phase is 0, i.e. the wrap 2N-1→0; REVS wraps from all-ones to 0.
  - J legal, J!=succ(prev), J!=prev (skip or backward step):
    - ERR<=1, STEP=0.
    - PHASE resyncs to decode(J); no REVS change.
    - Exception: if prev was illegal, this is a recovery; no new ERR set.
  - J illegal: VALID=0, ONEHOT=0, PHASE holds last legal value, ERR<=1, STEP=0.
- Latency: all outputs registered; one cycle from J sample to output.
- VALID=1 implies ONEHOT = 1<<PHASE.
- CLR: clears ERR and REVS next edge. If an error or a revolution occurs in the same cycle as CLR, the set/increment wins (ERR=1, REVS=1).
- RESET mid-operation: outputs clear immediately (async); decoding resumes on the first edge after RESET deasserts, using prev=0. A J≠0000 at that point is checked against prev=0.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then J steps 0000→0001→0011→0111→1111→1110→1100→1000→0000, each held 3 cycles → PHASE 0..7 then 0. STEP pulses exactly 8 times, one cycle each. ONEHOT 01h,02h,04h…80h,01h. REVS=1, ERR=0.
2. Drive 256 clean revolutions with REV_WIDTH=8 → REVS wraps 255→0; ERR stays 0.
3. From 0011 drive 0101 for 2 cycles, then 0111 → VALID=0, ONEHOT=00h, PHASE holds 2, ERR=1. On 0111: VALID=1, PHASE=3, STEP=0 (recovery, not a step).
4. From 0001 jump to 0111 (skip) → ERR=1, PHASE=3, STEP=0, REVS unchanged. Then 1111 → STEP=1, PHASE=4.
5. ERR=1 and REVS=5. Assert CLR for one cycle with an error-free J → ERR=0, REVS=0. Repeat with CLR coinciding with the 1000→0000 step → REVS=1. Repeat with CLR coinciding with an illegal code → ERR=1.
6. Assert RESET asynchronously between edges at phase 5 → all outputs 0 before the next edge. Release with J=1110 → ERR=1 on the first edge (0000→1110 is not a successor).
